// File: rtl/exec_mc_pkg.sv
// Shared types and constants for the exec_mc execute stage.
package exec_mc_pkg;

  // Execute-stage sequencing states.
  typedef enum logic {
    EXEC_RUN   = 1'b0,
    EXEC_SHIFT = 1'b1
  } exec_state_e;

  // Register-file sign/zero-extension codes passed through to writeback.
  localparam logic [2:0] XRS_NONE = 3'd0;
  localparam logic [2:0] XRS_S8   = 3'd1;
  localparam logic [2:0] XRS_S16  = 3'd2;
  localparam logic [2:0] XRS_S32  = 3'd3;
  localparam logic [2:0] XRS_S64  = 3'd4;
  localparam logic [2:0] XRS_U8   = 3'd5;
  localparam logic [2:0] XRS_U16  = 3'd6;
  localparam logic [2:0] XRS_U32  = 3'd7;

  // Width of a shift amount for a given datapath width.
  function automatic int unsigned shamt_width(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/exec_shifter.sv
// Iterative barrel shifter: moves at most SHIFT_STEP positions per clock.
// res_c_o is the value after the current step, so the owner can capture the
// finished result on the same edge that performs the last step.
module exec_shifter
  import exec_mc_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_i,
  input  logic [XLEN-1:0]          value_i,
  input  logic [$clog2(XLEN)-1:0]  shamt_i,
  input  logic                     left_i,
  input  logic                     arith_i,
  output logic [XLEN-1:0]          res_c_o,
  output logic                     last_c_o
);

  localparam int unsigned SHW = shamt_width(XLEN);
  localparam int unsigned CW  = SHW + 1;

  logic [XLEN-1:0] value_q;
  logic [XLEN-1:0] value_d;
  logic [SHW-1:0]  rem_q;
  logic [SHW-1:0]  rem_d;
  logic            left_q;
  logic            arith_q;
  logic [CW-1:0]   step_c;

  // Step size and next value/remaining count for one shift iteration.
  always_comb begin
    step_c = (CW'(rem_q) > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : CW'(rem_q);
    if (left_q) begin
      value_d = value_q << step_c;
    end else if (arith_q) begin
      value_d = $unsigned($signed(value_q) >>> step_c);
    end else begin
      value_d = value_q >> step_c;
    end
    rem_d = rem_q - SHW'(step_c);
  end

  assign res_c_o  = value_d;
  assign last_c_o = (CW'(rem_q) <= CW'(SHIFT_STEP));

  // Load a new operation or advance the one in flight; idles harmlessly at rem 0.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      value_q <= '0;
      rem_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      value_q <= value_i;
      rem_q   <= shamt_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else begin
      value_q <= value_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: rtl/exec_mc.sv
// Execute stage: single-cycle ALU plus iterative shifter behind a valid/ready
// handshake, with registered result and passthrough memory/writeback controls.
module exec_mc
  import exec_mc_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] inpa_i,
  input  logic [XLEN-1:0] inpb_i,
  input  logic            invB_i,
  input  logic            cflag_i,
  input  logic            lsh_en_i,
  input  logic            rsh_en_i,
  input  logic            sra_i,
  input  logic            wordop_i,
  input  logic            sum_en_i,
  input  logic            and_en_i,
  input  logic            xor_en_i,
  input  logic            ltu_en_i,
  input  logic            lts_en_i,
  input  logic [4:0]      rd_i,
  input  logic            we_i,
  input  logic            nomem_i,
  input  logic            mem_i,
  input  logic [XLEN-1:0] dat_i,
  input  logic [2:0]      xrs_rwe_i,
  input  logic            busy_i,
  output logic            valid_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] addr_o,
  output logic            we_o,
  output logic            nomem_o,
  output logic            mem_o,
  output logic [XLEN-1:0] dat_o,
  output logic [2:0]      xrs_rwe_o
);

  localparam int unsigned    SHW      = shamt_width(XLEN);
  localparam logic           HAS_WORD = 1'(XLEN == 64);
  localparam logic [XLEN-1:0] HI_MASK = ~XLEN'(32'hFFFF_FFFF);

  // Sign-extend from bit 31 (identity when XLEN is 32).
  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return x[31] ? (x | HI_MASK) : (x & ~HI_MASK);
  endfunction

  // Zero the bits above 31 (identity when XLEN is 32).
  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return x & ~HI_MASK;
  endfunction

  exec_state_e state_q;

  logic            valid_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q;
  logic            we_q;
  logic            nomem_q;
  logic            mem_q;
  logic [XLEN-1:0] dat_q;
  logic [2:0]      xrs_q;

  // Controls captured at shift accept, released when the shift finishes.
  logic [4:0]      pend_rd_q;
  logic            pend_we_q;
  logic            pend_nomem_q;
  logic            pend_mem_q;
  logic [XLEN-1:0] pend_dat_q;
  logic [2:0]      pend_xrs_q;
  logic            pend_word_q;

  logic            word_c;
  logic [XLEN-1:0] a_c;
  logic [XLEN-1:0] b_c;
  logic [XLEN-1:0] sum_c;
  logic            ltu_c;
  logic            lts_c;
  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] alu_res_c;
  logic [SHW-1:0]  shamt_c;
  logic            is_shift_c;
  logic [XLEN-1:0] sh_opnd_c;
  logic [XLEN-1:0] direct_res_c;
  logic [XLEN-1:0] sh_res_c;
  logic            sh_last_c;
  logic [XLEN-1:0] fin_res_c;
  logic            ready_c;
  logic            accept_c;
  logic            load_c;

  // ALU operands, unit results and the OR-combined single-cycle result.
  always_comb begin
    word_c    = HAS_WORD & wordop_i;
    a_c       = word_c ? sext32(inpa_i) : inpa_i;
    b_c       = word_c ? sext32(inpb_i) : inpb_i;
    sum_c     = a_c + (invB_i ? ~b_c : b_c) + XLEN'(cflag_i);
    ltu_c     = (a_c < b_c);
    lts_c     = ($signed(a_c) < $signed(b_c));
    alu_c     = (sum_en_i ? sum_c       : '0)
              | (and_en_i ? (a_c & b_c) : '0)
              | (xor_en_i ? (a_c ^ b_c) : '0)
              | (ltu_en_i ? XLEN'(ltu_c) : '0)
              | (lts_en_i ? XLEN'(lts_c) : '0);
    alu_res_c = word_c ? sext32(alu_c) : alu_c;
  end

  // Shift operand prep; word SRA pre-extends so the fill comes from bit 31.
  always_comb begin
    shamt_c    = word_c ? SHW'(inpb_i[4:0]) : inpb_i[SHW-1:0];
    is_shift_c = lsh_en_i | rsh_en_i;
    if (!word_c) begin
      sh_opnd_c = inpa_i;
    end else if (rsh_en_i && sra_i && !lsh_en_i) begin
      sh_opnd_c = sext32(inpa_i);
    end else begin
      sh_opnd_c = zext32(inpa_i);
    end
    direct_res_c = is_shift_c ? (word_c ? sext32(sh_opnd_c) : sh_opnd_c) : alu_res_c;
    fin_res_c    = pend_word_q ? sext32(sh_res_c) : sh_res_c;
  end

  // Handshake: accept only when idle, not stalled and out of reset.
  always_comb begin
    ready_c  = reset_i & (state_q == EXEC_RUN) & ~busy_i;
    accept_c = valid_i & ready_c;
    load_c   = accept_c & is_shift_c & (shamt_c != '0);
  end

  exec_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (load_c),
    .value_i  (sh_opnd_c),
    .shamt_i  (shamt_c),
    .left_i   (lsh_en_i),
    .arith_i  (sra_i),
    .res_c_o  (sh_res_c),
    .last_c_o (sh_last_c)
  );

  // Sequencer and output registers; busy_i freezes every output register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= EXEC_RUN;
      valid_q      <= 1'b0;
      rd_q         <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      nomem_q      <= 1'b0;
      mem_q        <= 1'b0;
      dat_q        <= '0;
      xrs_q        <= '0;
      pend_rd_q    <= '0;
      pend_we_q    <= 1'b0;
      pend_nomem_q <= 1'b0;
      pend_mem_q   <= 1'b0;
      pend_dat_q   <= '0;
      pend_xrs_q   <= '0;
      pend_word_q  <= 1'b0;
    end else begin
      case (state_q)
        EXEC_RUN: begin
          if (load_c) begin
            state_q      <= EXEC_SHIFT;
            valid_q      <= 1'b0;
            pend_rd_q    <= rd_i;
            pend_we_q    <= we_i;
            pend_nomem_q <= nomem_i;
            pend_mem_q   <= mem_i;
            pend_dat_q   <= dat_i;
            pend_xrs_q   <= xrs_rwe_i;
            pend_word_q  <= word_c;
          end else if (accept_c) begin
            valid_q <= 1'b1;
            rd_q    <= rd_i;
            addr_q  <= direct_res_c;
            we_q    <= we_i;
            nomem_q <= nomem_i;
            mem_q   <= mem_i;
            dat_q   <= dat_i;
            xrs_q   <= xrs_rwe_i;
          end else if (!busy_i) begin
            valid_q <= 1'b0;
          end
        end
        EXEC_SHIFT: begin
          if (!busy_i) begin
            if (sh_last_c) begin
              state_q <= EXEC_RUN;
              valid_q <= 1'b1;
              rd_q    <= pend_rd_q;
              addr_q  <= fin_res_c;
              we_q    <= pend_we_q;
              nomem_q <= pend_nomem_q;
              mem_q   <= pend_mem_q;
              dat_q   <= pend_dat_q;
              xrs_q   <= pend_xrs_q;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= EXEC_RUN;
      endcase
    end
  end

  assign ready_o   = ready_c;
  assign valid_o   = valid_q;
  assign rd_o      = rd_q;
  assign addr_o    = addr_q;
  assign we_o      = we_q;
  assign nomem_o   = nomem_q;
  assign mem_o     = mem_q;
  assign dat_o     = dat_q;
  assign xrs_rwe_o = xrs_q;

endmodule

// File: tb/tb_exec_mc.sv
// Bench for exec_mc (XLEN=64, SHIFT_STEP=8): table of ops with expected result
// and latency, scoreboard-checked outputs, plus stall/abort sequences.
module tb_exec_mc;
  import exec_mc_pkg::*;

  logic        clk;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] inpa_i;
  logic [63:0] inpb_i;
  logic        invB_i, cflag_i, lsh_en_i, rsh_en_i, sra_i, wordop_i;
  logic        sum_en_i, and_en_i, xor_en_i, ltu_en_i, lts_en_i;
  logic [4:0]  rd_i;
  logic        we_i, nomem_i, mem_i;
  logic [63:0] dat_i;
  logic [2:0]  xrs_rwe_i;
  logic        busy_i;
  logic        valid_o;
  logic [4:0]  rd_o;
  logic [63:0] addr_o;
  logic        we_o, nomem_o, mem_o;
  logic [63:0] dat_o;
  logic [2:0]  xrs_rwe_o;

  exec_mc #(.XLEN(64), .SHIFT_STEP(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .inpa_i(inpa_i), .inpb_i(inpb_i), .invB_i(invB_i), .cflag_i(cflag_i),
    .lsh_en_i(lsh_en_i), .rsh_en_i(rsh_en_i), .sra_i(sra_i), .wordop_i(wordop_i),
    .sum_en_i(sum_en_i), .and_en_i(and_en_i), .xor_en_i(xor_en_i),
    .ltu_en_i(ltu_en_i), .lts_en_i(lts_en_i),
    .rd_i(rd_i), .we_i(we_i), .nomem_i(nomem_i), .mem_i(mem_i), .dat_i(dat_i),
    .xrs_rwe_i(xrs_rwe_i), .busy_i(busy_i),
    .valid_o(valid_o), .rd_o(rd_o), .addr_o(addr_o), .we_o(we_o),
    .nomem_o(nomem_o), .mem_o(mem_o), .dat_o(dat_o), .xrs_rwe_o(xrs_rwe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] C_SUM  = 11'h001;
  localparam logic [10:0] C_AND  = 11'h002;
  localparam logic [10:0] C_XOR  = 11'h004;
  localparam logic [10:0] C_LTU  = 11'h008;
  localparam logic [10:0] C_LTS  = 11'h010;
  localparam logic [10:0] C_INVB = 11'h020;
  localparam logic [10:0] C_CIN  = 11'h040;
  localparam logic [10:0] C_WORD = 11'h080;
  localparam logic [10:0] C_LSH  = 11'h100;
  localparam logic [10:0] C_RSH  = 11'h200;
  localparam logic [10:0] C_SRA  = 11'h400;
  localparam logic [10:0] C_CMP  = C_INVB | C_CIN;
  localparam int          NVEC   = 21;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [10:0] ctl;
    logic [4:0]  rd;
    logic        we;
    logic        nomem;
    logic        mem;
    logic [63:0] dat;
    logic [2:0]  xrs;
    logic [63:0] exp_addr;
    int          exp_lat;
  } vec_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [4:0]  rd;
    logic        we;
    logic        nomem;
    logic        mem;
    logic [2:0]  xrs;
    logic [63:0] dat;
  } exp_t;

  vec_t tbl [NVEC];
  exp_t sb [$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_busy;
  logic mon_rst;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int idx, input logic [63:0] a, input logic [63:0] b,
                              input logic [10:0] ctl, input logic [63:0] ex, input int lat);
    vec_t v;
    logic [31:0] iv;
    iv = idx;
    v.a = a; v.b = b; v.ctl = ctl;
    v.rd = iv[4:0]; v.we = iv[0]; v.nomem = iv[1]; v.mem = iv[2];
    v.dat = 64'hC0DE_0000_0000_0000 | 64'(iv);
    v.xrs = iv[2:0];
    v.exp_addr = ex; v.exp_lat = lat;
    return v;
  endfunction

  function automatic logic [159:0] outs();
    return 160'({valid_o, rd_o, addr_o, we_o, nomem_o, mem_o, dat_o, xrs_rwe_o});
  endfunction

  task automatic drive(input vec_t v);
    inpa_i = v.a; inpb_i = v.b;
    sum_en_i = v.ctl[0]; and_en_i = v.ctl[1]; xor_en_i = v.ctl[2];
    ltu_en_i = v.ctl[3]; lts_en_i = v.ctl[4]; invB_i = v.ctl[5]; cflag_i = v.ctl[6];
    wordop_i = v.ctl[7]; lsh_en_i = v.ctl[8]; rsh_en_i = v.ctl[9]; sra_i = v.ctl[10];
    rd_i = v.rd; we_i = v.we; nomem_i = v.nomem; mem_i = v.mem;
    dat_i = v.dat; xrs_rwe_i = v.xrs;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.addr = v.exp_addr; e.rd = v.rd; e.we = v.we; e.nomem = v.nomem;
    e.mem = v.mem; e.xrs = v.xrs; e.dat = v.dat;
    sb.push_back(e);
  endtask

  // Present one op, wait for accept, then wait for the scoreboard to drain.
  task automatic run_op(input vec_t v, output int lat);
    int w;
    @(negedge clk);
    drive(v);
    valid_i = 1'b1;
    #1;
    w = 0;
    while (!ready_o && w < 40) begin
      @(negedge clk); #1; w++;
    end
    if (!ready_o) begin
      check("accept_timeout", 160'(ready_o), 160'd1);
      valid_i = 1'b0;
      lat = 0;
      return;
    end
    push_exp(v);
    @(posedge clk);
    lat = 1;
    #2;
    valid_i = 1'b0;
    while (sb.size() != 0 && lat < 30) begin
      @(posedge clk); lat++; #2;
    end
    if (sb.size() != 0) begin
      check("result_timeout", 160'(sb.size()), 160'd0);
      sb.delete();
    end
  endtask

  // Scoreboard monitor: a new result is any unstalled, non-reset edge leaving valid_o high.
  always begin
    @(posedge clk);
    mon_busy = busy_i;
    mon_rst  = reset_i;
    #1;
    if (mon_rst && !mon_busy && valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 160'(valid_o), 160'd0);
      end else begin
        mon_e = sb.pop_front();
        check("addr", 160'(addr_o), 160'(mon_e.addr));
        check("ctrl", 160'({rd_o, we_o, nomem_o, mem_o, xrs_rwe_o, dat_o}),
              160'({mon_e.rd, mon_e.we, mon_e.nomem, mon_e.mem, mon_e.xrs, mon_e.dat}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    vec_t v;

    tbl[0]  = mk(0,  64'hE00000, 64'hFFFF_FFFF_FFFF_F800, C_SUM, 64'hDFF800, 1);
    tbl[0].rd = 5'd23; tbl[0].mem = 1'b1; tbl[0].we = 1'b0; tbl[0].nomem = 1'b0;
    tbl[0].xrs = XRS_S16; tbl[0].dat = 64'd0;
    tbl[1]  = mk(1,  64'hE00000, 64'h7FF, C_SUM, 64'hE007FF, 1);
    tbl[1].rd = 5'd0; tbl[1].we = 1'b1; tbl[1].mem = 1'b1; tbl[1].nomem = 1'b0;
    tbl[1].dat = 64'hDEAD; tbl[1].xrs = XRS_NONE;
    tbl[2]  = mk(2,  64'd5, 64'd7, C_LTS | C_CMP, 64'd1, 1);
    tbl[3]  = mk(3,  '1, 64'd1, C_LTU | C_CMP, 64'd0, 1);
    tbl[4]  = mk(4,  '1, 64'd1, C_LTS | C_CMP, 64'd1, 1);
    tbl[5]  = mk(5,  64'd1, 64'd20, C_LSH, 64'h10_0000, 4);
    tbl[6]  = mk(6,  64'd1, 64'd0, C_LSH, 64'd1, 1);
    tbl[7]  = mk(7,  64'h8000_0000, 64'd4, C_WORD | C_RSH | C_SRA, 64'hFFFF_FFFF_F800_0000, 2);
    tbl[8]  = mk(8,  64'h7FFF_FFFF, 64'd1, C_WORD | C_SUM, 64'hFFFF_FFFF_8000_0000, 1);
    tbl[9]  = mk(9,  64'hF0F0, 64'hFF00, C_AND | C_XOR, 64'hFFF0, 1);
    tbl[10] = mk(10, 64'd10, 64'd3, C_SUM | C_CMP, 64'd7, 1);
    tbl[11] = mk(11, 64'h8000_0000_0000_0000, 64'd63, C_RSH, 64'd1, 9);
    tbl[12] = mk(12, 64'h8000_0000_0000_0000, 64'd63, C_RSH | C_SRA, '1, 9);
    tbl[13] = mk(13, 64'hF0, 64'h44, C_RSH, 64'hF, 2);
    tbl[14] = mk(14, 64'd1, 64'd31, C_WORD | C_LSH, 64'hFFFF_FFFF_8000_0000, 5);
    tbl[15] = mk(15, 64'hFFFF_FFFF_8000_0000, 64'd1, C_WORD | C_RSH, 64'h4000_0000, 2);
    tbl[16] = mk(16, '1, 64'd1, C_SUM, 64'd0, 1);
    tbl[17] = mk(17, 64'hFF, 64'h0F, C_XOR, 64'hF0, 1);
    tbl[18] = mk(18, 64'hAAAA_0000_0000_0001, 64'h5555_0000_0000_0002, C_WORD | C_LTU | C_CMP, 64'd1, 1);
    tbl[19] = mk(19, 64'hAAAA_0000_0000_0001, 64'h5555_0000_0000_0002, C_LTU | C_CMP, 64'd0, 1);
    tbl[20] = mk(20, 64'h8000_0000_0000_0000, 64'd8, C_RSH | C_SRA, 64'hFF80_0000_0000_0000, 2);

    reset_i = 1'b0; busy_i = 1'b0; valid_i = 1'b0;
    v = mk(0, 64'd0, 64'd0, 11'd0, 64'd0, 1);
    drive(v);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset_outputs", outs(), 160'd0);
    check("reset_ready", 160'(ready_o), 160'd0);
    @(negedge clk); reset_i = 1'b1;
    #1;
    check("ready_after_reset", 160'(ready_o), 160'd1);

    // Table-driven ops: result via scoreboard, latency checked here
    for (int i = 0; i < NVEC; i++) begin
      run_op(tbl[i], lat);
      check($sformatf("latency[%0d]", i), 160'(lat), 160'(tbl[i].exp_lat));
    end

    // Stall after a result: outputs held, inputs ignored
    run_op(tbl[9], lat);
    busy_i = 1'b1;
    drive(tbl[10]);
    valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 160'(ready_o), 160'd0);
      @(posedge clk); #2;
      check("stall_hold", outs(), 160'({1'b1, tbl[9].rd, 64'hFFF0, tbl[9].we, tbl[9].nomem,
                                        tbl[9].mem, tbl[9].dat, tbl[9].xrs}));
    end
    @(negedge clk); busy_i = 1'b0; valid_i = 1'b0;
    @(posedge clk); #2;
    check("bubble_valid", 160'(valid_o), 160'd0);
    check("bubble_addr_hold", 160'(addr_o), 160'h0FFF0);

    // Busy when the shift completes: result appears only on release
    v = mk(5, 64'd1, 64'd8, C_LSH, 64'h100, 2);
    @(negedge clk); drive(v); valid_i = 1'b1;
    #1;
    check("shift_accept_ready", 160'(ready_o), 160'd1);
    push_exp(v);
    @(posedge clk); #2;
    valid_i = 1'b0; busy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      check("busy_shift_no_valid", 160'(valid_o), 160'd0);
    end
    busy_i = 1'b0;
    @(posedge clk); #2;
    check("release_valid", 160'(valid_o), 160'd1);
    check("release_drained", 160'(sb.size()), 160'd0);

    // Reset with dirty outputs
    @(negedge clk); reset_i = 1'b0;
    @(posedge clk); #2;
    check("dirty_reset_outputs", outs(), 160'd0);
    check("dirty_reset_ready", 160'(ready_o), 160'd0);
    @(negedge clk); reset_i = 1'b1;

    // Reset mid-shift aborts the op
    v = mk(7, 64'd1, 64'd40, C_LSH, 64'h100_0000_0000, 6);
    @(negedge clk); drive(v); valid_i = 1'b1;
    #1;
    push_exp(v);
    @(posedge clk); #2;
    valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk); reset_i = 1'b0;
    @(posedge clk); #2;
    check("abort_outputs", outs(), 160'd0);
    check("abort_ready", 160'(ready_o), 160'd0);
    sb.delete();
    @(negedge clk); reset_i = 1'b1;
    #1;
    check("abort_ready_after", 160'(ready_o), 160'd1);
    repeat (8) @(posedge clk);
    #2;
    check("abort_no_result", 160'(valid_o), 160'd0);

    // Normal ops after abort
    run_op(tbl[5], lat);
    check("post_abort_latency", 160'(lat), 160'(tbl[5].exp_lat));
    run_op(tbl[0], lat);
    check("post_abort_load_latency", 160'(lat), 160'd1);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
